// File: rtl/demux_stream_n.sv
// demux_stream_n: 1:N valid/ready packet demultiplexer with per-channel output register
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mode                    0 = route by in_sel, 1 = round-robin (sampled on first beat)
//   in_valid/ready/data/last/sel  input stream; in_sel sampled on first beat only
//   out_valid/ready/data/last     per-channel streams, channel k data at [k*DATA_W +: DATA_W]
//   cur_ch                  locked channel, else next target (0 when dropping or invalid)
//   drop_err                one-cycle pulse after the first beat of a dropped packet
module demux_stream_n #(
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_last,
    output logic [SEL_W-1:0]         cur_ch,
    output logic                     drop_err
);
    localparam logic [1:0] IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2;
    logic [1:0]       state;
    logic [SEL_W-1:0] lock_ch, rr_ptr, tgt;
    logic             pkt_rr, tgt_ok, ch_free, acc, drop_start, rr_adv;
    logic [N_CH-1:0]  hit, wr;
    always_comb begin
        tgt        = state == FWD ? lock_ch : mode ? rr_ptr : in_sel;
        tgt_ok     = state == FWD || mode || int'(in_sel) < N_CH;
        // only the targeted channel's occupancy gates the input
        ch_free    = |(hit & (~out_valid | out_ready));
        in_ready   = state == DROP || !tgt_ok || ch_free;
        acc        = in_valid && in_ready;
        wr         = (acc && state != DROP && tgt_ok) ? hit : '0;
        drop_start = acc && state == IDLE && !tgt_ok;
        // round-robin mode is remembered from the first beat for multi-beat packets
        rr_adv     = acc && in_last && (state == IDLE ? mode : (state == FWD && pkt_rr));
        cur_ch     = (state == DROP || !tgt_ok) ? '0 : tgt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_ch  <= '0;
            rr_ptr   <= '0;
            pkt_rr   <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            drop_err <= drop_start;
            if (rr_adv) rr_ptr <= rr_ptr == SEL_W'(N_CH - 1) ? '0 : rr_ptr + 1'b1;
            if (acc && state == IDLE && !in_last) begin
                state   <= tgt_ok ? FWD : DROP;
                lock_ch <= tgt;
                pkt_rr  <= mode;
            end else if (acc && state != IDLE && in_last) begin
                state <= IDLE;
            end
        end
    end
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic              v, l;
        logic [DATA_W-1:0] d;
        assign hit[k]                       = tgt == SEL_W'(k);
        assign out_valid[k]                 = v;
        assign out_last[k]                  = l;
        assign out_data[k*DATA_W +: DATA_W] = d;
        // a write in the same cycle as a drain keeps v high for full throughput
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                l <= 1'b0;
                d <= '0;
            end else if (wr[k]) begin
                v <= 1'b1;
                l <= in_last;
                d <= in_data;
            end else if (out_ready[k]) begin
                v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_demux_stream_n.sv
// tb_demux_stream_n: directed table-driven bench for demux_stream_n
module tb_demux_stream_n;
    logic        clk = 0, rst_n = 0;
    logic        mode = 0, in_valid = 0, in_last = 0, in_ready, drop_err;
    logic [7:0]  in_data = 0;
    logic [1:0]  in_sel = 0, cur_ch;
    logic [3:0]  out_valid, out_ready = 4'hF, out_last;
    logic [31:0] out_data;
    logic        v3 = 0, l3 = 0, rdy3, de3;
    logic [7:0]  d3 = 0;
    logic [1:0]  s3 = 0, cur3;
    logic [2:0]  ov3, or3 = 3'b111, ol3;
    logic [23:0] od3;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    demux_stream_n #(.N_CH(4), .SEL_W(2), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .cur_ch(cur_ch),
        .drop_err(drop_err));

    demux_stream_n #(.N_CH(3), .SEL_W(2), .DATA_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(1'b0), .in_valid(v3), .in_ready(rdy3),
        .in_data(d3), .in_last(l3), .in_sel(s3), .out_valid(ov3),
        .out_ready(or3), .out_data(od3), .out_last(ol3), .cur_ch(cur3),
        .drop_err(de3));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic md, v; logic [7:0] d; logic l; logic [1:0] s; logic [3:0] r;
        logic e_rdy; logic [3:0] e_ov; logic [1:0] e_cur; logic [31:0] e_dat; logic [3:0] e_last;
    } vec_t;
    vec_t vt [24];

    initial begin
        logic [31:0] m;
        int pulses;
        logic [2:0] ov_seen;
        vt[0]  = '{1'b0,1'b0,8'h00,1'b0,2'd0,4'hF, 1'b1,4'b0000,2'd0,32'h0000_0000,4'b0000};
        vt[1]  = '{1'b0,1'b1,8'hA1,1'b0,2'd2,4'hF, 1'b1,4'b0000,2'd2,32'h0000_0000,4'b0000};
        vt[2]  = '{1'b0,1'b1,8'hA2,1'b0,2'd2,4'hF, 1'b1,4'b0100,2'd2,32'h00A1_0000,4'b0000};
        vt[3]  = '{1'b0,1'b1,8'hA3,1'b1,2'd2,4'hF, 1'b1,4'b0100,2'd2,32'h00A2_0000,4'b0000};
        vt[4]  = '{1'b0,1'b1,8'hB1,1'b1,2'd0,4'hF, 1'b1,4'b0100,2'd0,32'h00A3_0000,4'b0100};
        vt[5]  = '{1'b0,1'b0,8'h00,1'b0,2'd0,4'hF, 1'b1,4'b0001,2'd0,32'h0000_00B1,4'b0001};
        vt[6]  = '{1'b0,1'b1,8'hC1,1'b0,2'd1,4'hF, 1'b1,4'b0000,2'd1,32'h0000_0000,4'b0000};
        vt[7]  = '{1'b0,1'b1,8'hC2,1'b0,2'd3,4'hF, 1'b1,4'b0010,2'd1,32'h0000_C100,4'b0000};
        vt[8]  = '{1'b0,1'b1,8'hC3,1'b1,2'd3,4'hF, 1'b1,4'b0010,2'd1,32'h0000_C200,4'b0000};
        vt[9]  = '{1'b0,1'b0,8'h00,1'b0,2'd0,4'hF, 1'b1,4'b0010,2'd0,32'h0000_C300,4'b0010};
        vt[10] = '{1'b1,1'b1,8'hD0,1'b1,2'd0,4'hF, 1'b1,4'b0000,2'd0,32'h0000_0000,4'b0000};
        vt[11] = '{1'b1,1'b1,8'hD1,1'b1,2'd0,4'hF, 1'b1,4'b0001,2'd1,32'h0000_00D0,4'b0001};
        vt[12] = '{1'b1,1'b1,8'hD2,1'b1,2'd0,4'hF, 1'b1,4'b0010,2'd2,32'h0000_D100,4'b0010};
        vt[13] = '{1'b1,1'b1,8'hD3,1'b1,2'd0,4'hF, 1'b1,4'b0100,2'd3,32'h00D2_0000,4'b0100};
        vt[14] = '{1'b1,1'b1,8'hD4,1'b1,2'd0,4'hF, 1'b1,4'b1000,2'd0,32'hD300_0000,4'b1000};
        vt[15] = '{1'b1,1'b1,8'hD5,1'b1,2'd0,4'hF, 1'b1,4'b0001,2'd1,32'h0000_00D4,4'b0001};
        vt[16] = '{1'b1,1'b0,8'h00,1'b0,2'd0,4'hF, 1'b1,4'b0010,2'd2,32'h0000_D500,4'b0010};
        vt[17] = '{1'b0,1'b1,8'hE1,1'b1,2'd1,4'hD, 1'b1,4'b0000,2'd1,32'h0000_0000,4'b0000};
        vt[18] = '{1'b0,1'b1,8'hE2,1'b1,2'd1,4'hD, 1'b0,4'b0010,2'd1,32'h0000_E100,4'b0010};
        vt[19] = '{1'b0,1'b1,8'hF1,1'b0,2'd2,4'hD, 1'b1,4'b0010,2'd2,32'h0000_E100,4'b0010};
        vt[20] = '{1'b0,1'b1,8'hF2,1'b1,2'd2,4'hD, 1'b1,4'b0110,2'd2,32'h00F1_E100,4'b0010};
        vt[21] = '{1'b0,1'b1,8'hE2,1'b1,2'd1,4'hF, 1'b1,4'b0110,2'd1,32'h00F2_E100,4'b0110};
        vt[22] = '{1'b0,1'b0,8'h00,1'b0,2'd0,4'hF, 1'b1,4'b0010,2'd0,32'h0000_E200,4'b0010};
        vt[23] = '{1'b0,1'b0,8'h00,1'b0,2'd0,4'hF, 1'b1,4'b0000,2'd0,32'h0000_0000,4'b0000};

        repeat (3) @(negedge clk);
        check("reset out_data", out_data, 0);
        check("reset out_last", {28'd0, out_last}, 0);
        rst_n = 1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            {mode, in_valid, in_data, in_last, in_sel, out_ready} =
                {vt[i].md, vt[i].v, vt[i].d, vt[i].l, vt[i].s, vt[i].r};
            #1;
            for (int k = 0; k < 4; k++) m[k*8 +: 8] = {8{vt[i].e_ov[k]}};
            check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].e_rdy});
            check($sformatf("v%0d out_valid", i), {28'd0, out_valid}, {28'd0, vt[i].e_ov});
            check($sformatf("v%0d cur_ch", i), {30'd0, cur_ch}, {30'd0, vt[i].e_cur});
            check($sformatf("v%0d out_data", i), out_data & m, vt[i].e_dat & m);
            check($sformatf("v%0d out_last", i), {28'd0, out_last & vt[i].e_ov},
                  {28'd0, vt[i].e_last & vt[i].e_ov});
            check($sformatf("v%0d drop_err", i), {31'd0, drop_err}, 0);
        end

        // invalid select on the 3-channel instance: 4-beat packet to sel=3
        pulses = 0;
        ov_seen = 0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            v3 = 1; s3 = 2'd3; l3 = (b == 3); d3 = 8'h90 + 8'(b);
            #1;
            check($sformatf("drop b%0d in_ready", b), {31'd0, rdy3}, 1);
            check($sformatf("drop b%0d cur_ch", b), {30'd0, cur3}, 0);
            check($sformatf("drop b%0d drop_err", b), {31'd0, de3}, {31'd0, b == 1});
            pulses += int'(de3);
            ov_seen |= ov3;
        end
        @(negedge clk);
        v3 = 1; s3 = 2'd1; l3 = 1; d3 = 8'h55;
        #1;
        pulses += int'(de3);
        ov_seen |= ov3;
        check("drop pulse count", pulses, 1);
        check("drop no out_valid", {29'd0, ov_seen}, 0);
        check("post-drop cur_ch", {30'd0, cur3}, 1);
        @(negedge clk);
        v3 = 0;
        #1;
        check("post-drop out_valid", {29'd0, ov3}, 3'b010);
        check("post-drop out_data", {24'd0, od3[15:8]}, 8'h55);

        // reset in the middle of a packet with a beat stalled on ch0
        @(negedge clk);
        mode = 0; in_valid = 1; in_data = 8'h77; in_last = 0; in_sel = 0; out_ready = 0;
        #1;
        check("rst pre in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        in_data = 8'h78; in_sel = 2;
        #1;
        check("rst held out_valid", {28'd0, out_valid}, 4'b0001);
        check("rst stall in_ready", {31'd0, in_ready}, 0);
        check("rst locked cur_ch", {30'd0, cur_ch}, 0);
        #2 rst_n = 0;
        #1;
        check("rst async out_valid", {28'd0, out_valid}, 0);
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        in_valid = 1; in_data = 8'h79; in_last = 1; in_sel = 2; out_ready = 4'hF;
        #1;
        check("rst new cur_ch", {30'd0, cur_ch}, 2);
        check("rst new in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        in_valid = 0;
        #1;
        check("rst new out_valid", {28'd0, out_valid}, 4'b0100);
        check("rst new out_data", {24'd0, out_data[23:16]}, 8'h79);
        check("rst new out_last", {28'd0, out_last & 4'b0100}, 4'b0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_stream_n.md
Name: demux_stream_n

Overview:
Parametrised 1:N stream demultiplexer, successor to the combinational 1:4 demux.
Routes a valid/ready input stream of packets to one of N_CH output channels.
Each channel has a one-entry output register. A packet lock keeps every beat of a packet on one channel.
Two routing modes: direct (per-packet select input) and round-robin (internal pointer).

Parameters:
N_CH, 4, number of output channels (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= N_CH
DATA_W, 8, payload width per beat

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0 = direct (in_sel), 1 = round-robin
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  DATA_W  input payload
in_last  in  1  final beat of packet
in_sel  in  SEL_W  destination channel in direct mode, sampled on first beat only
out_valid  out  N_CH  per-channel valid
out_ready  in  N_CH  per-channel ready
out_data  out  N_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W]
out_last  out  N_CH  per-channel last flag
cur_ch  out  SEL_W  channel of the packet in flight, else next target
drop_err  out  1  one-cycle pulse on first beat of a dropped packet

Behaviour:
- Reset (async assert, sync-released use): out_valid=0, out_data=0, out_last=0, drop_err=0, cur_ch=0, rr_ptr=0, FSM=IDLE. Asserting reset mid-packet discards buffered beats and the packet lock.
- FSM states:
  - IDLE: no packet open.
  - FWD: packet open, locked to lock_ch.
  - DROP: packet open, being discarded.
- Target channel tgt:
  - IDLE: in_sel if mode=0, rr_ptr if mode=1.
  - FWD: lock_ch.
- mode and in_sel are sampled only on an IDLE-state accept. Changes mid-packet are ignored.
- in_ready:
  - FWD/IDLE with valid target: ready when !out_valid[tgt] | out_ready[tgt]. This is combinational from out_ready; no other channel's state affects it.
  - DROP, or IDLE with invalid target: ready=1.
- Invalid target: mode=0 and in_sel >= N_CH.
- Accept in IDLE, valid target:
  - Beat written into channel tgt register; out_valid[tgt]=1 next cycle (latency 1).
  - If !in_last, go to FWD with lock_ch=tgt.
- Accept in IDLE, invalid target:
  - Beat discarded, drop_err=1 for that cycle+1 (registered pulse, one cycle).
  - If !in_last, go to DROP.
- Accept in FWD: write into lock_ch. On in_last go to IDLE.
- Accept in DROP: discard. On in_last go to IDLE. No further drop_err pulses.
- Round-robin: rr_ptr advances on acceptance of a last beat routed in mode=1. Wrap: N_CH-1 -> 0. A single-beat packet (first beat has in_last) advances rr_ptr immediately.
- Channel register k:
  - Cleared (out_valid[k]=0) when out_valid[k] & out_ready[k] and no new write.
  - A simultaneous drain and write loads the new beat with out_valid[k] held at 1. This gives full throughput, one beat/cycle per channel.
- out_data/out_last of channel k hold value while out_valid[k] & !out_ready[k]. They are stable across backpressure.
- Channels drain independently. A stalled channel blocks input only while it is the target.
- cur_ch: lock_ch in FWD, otherwise tgt (0 in DROP or when invalid).

Test Plan:
- Direct mode, N_CH=4: packets of 3 beats to sel=2, then 1 beat to sel=0, all out_ready=1 -> out_valid[2] high 3 consecutive cycles, 1 cycle after each accept, last on 3rd; then out_valid[0] with out_last=1.
- Packet lock: sel=1 on beat 0, sel changes to 3 on beats 1-2 -> all 3 beats appear on channel 1, none on channel 3.
- Round-robin: 6 single-beat packets, mode=1 -> channels 0,1,2,3,0,1 in order; rr_ptr wraps 3->0.
- Backpressure: out_ready[1]=0 with a beat held on ch1 -> in_ready=0 for target 1, data held stable. Meanwhile a packet to ch2 flows. Raising out_ready[1] accepts the next beat the same cycle.
- Invalid select with N_CH=3: 4-beat packet with sel=3 -> in_ready=1 throughout, drop_err pulses once, no out_valid asserted, FSM back to IDLE after last.
- Reset mid-packet: assert rst_n=0 during FWD with ch0 holding a beat -> out_valid=0 immediately (async). After release, a new packet with sel=2 routes to ch2 as its first beat.
